vram_arbiter: RTL and testbench

Arbiter and access sequencer for the single-ported video SRAM: it shares the chip between the display pixel fetch (latency-critical, normally wins) and ISA memory cycles (held off with IOCHRDY). It generates the SRAM address, write strobe and data-bus enable with programmable setup and strobe timing. A wait counter guarantees ISA progress under continuous display traffic. It sits between the ISA decode/synchroniser logic and the SRAM pins, alongside the sequencer and pixel pipeline.

---
 rtl/vram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Video SRAM arbiter: shares the single-ported chip between pixel fetch
// and ISA cycles, sequencing address, write strobe and data-bus enable.
module vram_arbiter #(
  parameter int RD_SETUP  = 2,
  parameter int WE_CYCLES = 2,
  parameter int MAX_WAIT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isa_read,
  input  logic        isa_write,
  input  logic [18:0] isa_addr,
  input  logic [7:0]  isa_din,
  output logic [7:0]  isa_dout,
  output logic        isa_rdy,
  input  logic        pix_req,
  input  logic [18:0] pix_addr,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  output logic        pix_stall,
  output logic [18:0] ram_a,
  input  logic [7:0]  ram_d_in,
  output logic [7:0]  ram_d_out,
  output logic        ram_d_oe,
  output logic        ram_we_l
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD
  } state_t;

  localparam logic [3:0] RD_LAST  = 4'(RD_SETUP - 1);
  localparam logic [3:0] WE_LAST  = 4'(WE_CYCLES - 1);
  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic        pending;
  logic        pending_n;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_n;
  logic        strobe_q;
  logic        op_wr;
  logic [18:0] op_addr;
  logic [7:0]  op_data;
  logic        pix_q;

  logic [18:0] ram_a_n;
  logic [7:0]  ram_d_out_n;
  logic        ram_d_oe_n;
  logic        ram_we_l_n;
  logic        isa_rdy_n;
  logic [7:0]  isa_dout_n;

  logic        strobe;
  logic        start;
  logic        preempt;
  logic        force_isa;
  logic        pix_grant;
  logic        done;

  assign strobe    = isa_read | isa_write;
  assign start     = strobe & ~strobe_q
                   & ~pending & (state == IDLE);
  assign preempt   = (state == IDLE)
                   | (state == RD_ADDR)
                   | (state == WR_SETUP);
  assign force_isa = wait_cnt >= WAIT_LIM;
  assign pix_grant = pix_req & preempt & ~force_isa;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pending_n   = pending;
    wait_n      = wait_cnt;
    ram_a_n     = ram_a;
    ram_d_out_n = ram_d_out;
    ram_d_oe_n  = ram_d_oe;
    ram_we_l_n  = ram_we_l;
    isa_rdy_n   = isa_rdy;
    isa_dout_n  = isa_dout;
    done        = 1'b0;
    if (pix_grant) begin
      // Pixel steals the bus; any ISA setup in progress restarts later.
      state_n    = IDLE;
      cnt_n      = '0;
      ram_a_n    = pix_addr;
      ram_d_oe_n = 1'b0;
      if (pending && wait_cnt != 8'hff)
        wait_n = wait_cnt + 8'd1;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending) begin
            ram_a_n = op_addr;
            cnt_n   = '0;
            if (op_wr) begin
              state_n     = WR_SETUP;
              ram_d_out_n = op_data;
              ram_d_oe_n  = 1'b1;
            end else begin
              state_n = RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (cnt == RD_LAST) begin
            isa_dout_n = ram_d_in;
            done       = 1'b1;
            state_n    = IDLE;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        WR_SETUP: begin
          state_n    = WR_STROBE;
          ram_we_l_n = 1'b0;
          cnt_n      = '0;
        end
        WR_STROBE: begin
          if (cnt == WE_LAST) begin
            ram_we_l_n = 1'b1;
            state_n    = WR_HOLD;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        WR_HOLD: begin
          ram_d_oe_n = 1'b0;
          done       = 1'b1;
          state_n    = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
    if (done) begin
      pending_n = 1'b0;
      isa_rdy_n = 1'b1;
      wait_n    = '0;
    end
    if (start) begin
      pending_n = 1'b1;
      isa_rdy_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= 1'b0;
      wait_cnt  <= '0;
      strobe_q  <= 1'b0;
      op_wr     <= 1'b0;
      op_addr   <= '0;
      op_data   <= '0;
      ram_a     <= '0;
      ram_d_out <= '0;
      ram_d_oe  <= 1'b0;
      ram_we_l  <= 1'b1;
      isa_rdy   <= 1'b1;
      isa_dout  <= '0;
      pix_q     <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_stall <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pending   <= pending_n;
      wait_cnt  <= wait_n;
      strobe_q  <= strobe;
      ram_a     <= ram_a_n;
      ram_d_out <= ram_d_out_n;
      ram_d_oe  <= ram_d_oe_n;
      ram_we_l  <= ram_we_l_n;
      isa_rdy   <= isa_rdy_n;
      isa_dout  <= isa_dout_n;
      if (start) begin
        op_wr   <= isa_write;
        op_addr <= isa_addr;
        op_data <= isa_din;
      end
      pix_q     <= pix_grant;
      pix_valid <= pix_q;
      if (pix_q)
        pix_data <= ram_d_in;
      pix_stall <= pix_req & ~pix_grant;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: async SRAM model, pixel scoreboard,
// ISA read/write timing, forced ISA progress and reset abort.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        isa_read = 1'b0;
  logic        isa_write = 1'b0;
  logic [18:0] isa_addr = '0;
  logic [7:0]  isa_din = '0;
  logic [7:0]  isa_dout;
  logic        isa_rdy;
  logic        pix_req = 1'b0;
  logic [18:0] pix_addr = '0;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_stall;
  logic [18:0] ram_a;
  logic [7:0]  ram_d_in;
  logic [7:0]  ram_d_out;
  logic        ram_d_oe;
  logic        ram_we_l;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:4095];
  logic [7:0]  pix_exp [$];
  logic [7:0]  isa_exp [$];
  bit          pix_free = 1'b0;
  logic [7:0]  pix_fixed = '0;
  int          nvalid = 0;
  int          nstall = 0;
  int          nreq = 0;
  logic [18:0] prev_a = '0;
  logic [7:0]  prev_d = '0;
  logic        prev_we = 1'b1;

  vram_arbiter #(
    .RD_SETUP (2),
    .WE_CYCLES(2),
    .MAX_WAIT (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .isa_read (isa_read),
    .isa_write(isa_write),
    .isa_addr (isa_addr),
    .isa_din  (isa_din),
    .isa_dout (isa_dout),
    .isa_rdy  (isa_rdy),
    .pix_req  (pix_req),
    .pix_addr (pix_addr),
    .pix_data (pix_data),
    .pix_valid(pix_valid),
    .pix_stall(pix_stall),
    .ram_a    (ram_a),
    .ram_d_in (ram_d_in),
    .ram_d_out(ram_d_out),
    .ram_d_oe (ram_d_oe),
    .ram_we_l (ram_we_l)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5a;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  assign ram_d_in = mem[ram_a[11:0]];

  always @(posedge clk)
    if (!ram_we_l)
      mem[ram_a[11:0]] <= ram_d_out;

  always @(posedge clk)
    if (!reset && pix_req)
      nreq <= nreq + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (pix_stall)
        nstall <= nstall + 1;
      if (pix_valid) begin
        nvalid <= nvalid + 1;
        if (pix_exp.size() != 0)
          check("pix_data", pix_data, pix_exp.pop_front());
        else if (pix_free)
          check("pix_fixed", pix_data, pix_fixed);
        else
          check("pix_extra", 1, 0);
      end
      if (prev_we && !ram_we_l)
        check("we_setup",
              {ram_a != prev_a, ram_d_out != prev_d}, 0);
      if (!prev_we && ram_we_l)
        check("we_hold",
              {ram_a != prev_a, ram_d_out != prev_d}, 0);
      if (!ram_we_l)
        check("we_oe", ram_d_oe, 1);
    end
    prev_a  <= ram_a;
    prev_d  <= ram_d_out;
    prev_we <= ram_we_l;
  end

  // d is the write data, or the expected byte for a read.
  task automatic isa_op(input bit wr,
                        input logic [18:0] a,
                        input logic [7:0] d,
                        input int pix_at,
                        input logic [18:0] pa,
                        input bit pix_push,
                        output int low,
                        output int a_cyc,
                        output int we_cyc,
                        output int oe_cyc);
    bit fin = 1'b0;
    low = 0;
    a_cyc = 0;
    we_cyc = 0;
    oe_cyc = 0;
    @(posedge clk);
    #1;
    isa_write = wr;
    isa_read = !wr;
    isa_addr = a;
    isa_din = d;
    if (!wr)
      isa_exp.push_back(d);
    for (int c = 0; c < 300 && !fin; c++) begin
      @(posedge clk);
      #1;
      if (pix_at >= 0) begin
        pix_req = (c + 1 == pix_at);
        pix_addr = pa;
        if (pix_req && pix_push)
          pix_exp.push_back(pat(pa[11:0]));
      end
      @(negedge clk);
      if (isa_rdy) begin
        fin = 1'b1;
      end else begin
        low++;
        if (ram_a == a) a_cyc++;
        if (!ram_we_l) we_cyc++;
        if (ram_d_oe) oe_cyc++;
      end
    end
    check("rdy_timeout", fin, 1);
    isa_write = 1'b0;
    isa_read = 1'b0;
    if (!wr)
      check("isa_dout", isa_dout, isa_exp.pop_front());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int low, ac, wc, oc;
    int s_valid, s_stall, s_req, v_mid;
    for (int i = 0; i < 4096; i++)
      mem[i] <= pat(12'(i));
    mem[12'h234] <= 8'ha5;
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we_l", ram_we_l, 1);
    check("rst_oe", ram_d_oe, 0);
    check("rst_a", ram_a, 0);
    check("rst_dout", ram_d_out, 0);
    check("rst_rdy", isa_rdy, 1);
    check("rst_isa_dout", isa_dout, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_stall", pix_stall, 0);
    @(negedge clk);
    reset = 1'b0;

    isa_op(0, 19'h01234, 8'ha5, -1, '0, 0, low, ac, wc, oc);
    check("rd_low", low, 3);
    check("rd_addr", ac, 2);

    isa_op(1, 19'h00010, 8'h3c, -1, '0, 0, low, ac, wc, oc);
    check("wr_low", low, 5);
    check("wr_we", wc, 2);
    check("wr_oe", oc, 4);
    check("wr_oe_off", ram_d_oe, 0);
    check("wr_mem", mem[12'h010], 8'h3c);
    isa_op(0, 19'h00010, 8'h3c, -1, '0, 0, low, ac, wc, oc);
    check("rb_low", low, 3);

    @(posedge clk);
    #1;
    s_valid = nvalid;
    pix_req = 1'b1;
    pix_addr = 19'h00abc;
    pix_exp.push_back(pat(12'habc));
    @(posedge clk);
    #1;
    pix_req = 1'b0;
    @(negedge clk);
    check("lat_addr", ram_a, 19'h00abc);
    check("lat_valid0", pix_valid, 0);
    @(negedge clk);
    check("lat_valid1", pix_valid, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      pix_req = 1'b1;
      pix_addr = 19'h00100 + 19'(i * 7);
      pix_exp.push_back(pat(pix_addr[11:0]));
    end
    @(posedge clk);
    #1;
    pix_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("pix_drain", pix_exp.size(), 0);
    check("pix_burst", nvalid - s_valid, 9);

    pix_free = 1'b1;
    pix_fixed = pat(12'h200);
    @(posedge clk);
    #1;
    s_valid = nvalid;
    s_stall = nstall;
    s_req = nreq;
    pix_addr = 19'h00200;
    pix_req = 1'b1;
    isa_op(0, 19'h01234, 8'ha5, -1, '0, 0, low, ac, wc, oc);
    #1;
    v_mid = nvalid;
    check("f_low", low, 19);
    check("f_stall", nstall - s_stall, 3);
    repeat (4) @(posedge clk);
    #1;
    pix_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("f_resume", nvalid > v_mid, 1);
    check("f_cons",
          (nvalid - s_valid) + (nstall - s_stall),
          nreq - s_req);
    pix_free = 1'b0;

    @(posedge clk);
    #1;
    s_valid = nvalid;
    s_stall = nstall;
    isa_op(1, 19'h00020, 8'h55, 3, 19'h00300, 0,
           low, ac, wc, oc);
    #1;
    check("ws_low", low, 5);
    check("ws_we", wc, 2);
    check("ws_oe", oc, 4);
    check("ws_stall", nstall - s_stall, 1);
    check("ws_valid", nvalid - s_valid, 0);
    check("ws_mem", mem[12'h020], 8'h55);

    s_valid = nvalid;
    s_stall = nstall;
    isa_op(0, 19'h01234, 8'ha5, 2, 19'h00301, 1,
           low, ac, wc, oc);
    #1;
    check("rp_low", low, 5);
    check("rp_addr", ac, 3);
    check("rp_valid", nvalid - s_valid, 1);
    check("rp_stall", nstall - s_stall, 0);
    check("rp_drain", pix_exp.size(), 0);

    @(posedge clk);
    #1;
    isa_write = 1'b1;
    isa_addr = 19'h00030;
    isa_din = 8'h77;
    repeat (3) @(posedge clk);
    #2;
    check("ra_pre_we", ram_we_l, 0);
    reset = 1'b1;
    #1;
    check("ra_we", ram_we_l, 1);
    check("ra_oe", ram_d_oe, 0);
    check("ra_rdy", isa_rdy, 1);
    isa_write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    isa_op(1, 19'h00030, 8'h99, -1, '0, 0, low, ac, wc, oc);
    check("ra_low", low, 5);
    check("ra_we_cyc", wc, 2);
    check("ra_mem", mem[12'h030], 8'h99);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
